// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and redirect controller for the 5-stage pipeline.
// Detects load-use and ID-branch operand hazards and inserts bubbles.
// Flushes IF/ID on taken branches and jumps.
// Freezes everything while instruction memory is not ready.
// Keeps saturating stall and flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             id_jmp,
  input  logic             id_eq,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  output logic             PCwrite,
  output logic             IFIDwrite,
  output logic             IFIDflush,
  output logic             IDEXbubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         stall_left_q, stall_left_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic               stall_inc, flush_inc;

  logic               br, taken;
  logic               ex_match, mem_match;
  logic [1:0]         need_n;

  // Register 0 never carries a real dependency, so it never matches.
  assign ex_match  = (ex_rd  != 5'd0) &&
                     ((ex_rd  == id_rs) || (id_uses_rt && (ex_rd  == id_rt)));
  assign mem_match = (mem_rd != 5'd0) &&
                     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));
  assign br        = id_beq | id_bne;
  assign taken     = id_jmp | (id_beq & id_eq) | (id_bne & ~id_eq);

  // Stall demand: branches compare in ID, so they wait for ALU results one
  // cycle and for load data two cycles; plain ALU consumers only wait on loads.
  always_comb begin
    need_n = 2'd0;
    if (br && mem_memread && mem_match)                 need_n = 2'd1;
    if (br && ex_regwrite && !ex_memread && ex_match)   need_n = 2'd1;
    if (!br && ex_memread && ex_match)                  need_n = 2'd1;
    if (br && ex_memread && ex_match)                   need_n = 2'd2;
  end

  // Next-state and output decode; reset and freeze override the FSM.
  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    PCwrite      = 1'b1;
    IFIDwrite    = 1'b1;
    IFIDflush    = 1'b0;
    IDEXbubble   = 1'b0;
    pipe_hold    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (rst) begin
      PCwrite      = 1'b0;
      IFIDwrite    = 1'b0;
      IFIDflush    = 1'b1;
      IDEXbubble   = 1'b1;
      state_d      = RUN;
      stall_left_d = 2'd0;
    end else if (!imem_ready) begin
      // Frozen: nothing moves, state and counters hold.
      pipe_hold    = 1'b1;
      PCwrite      = 1'b0;
      IFIDwrite    = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (need_n != 2'd0) begin
            // Stall beats redirect; the branch re-resolves after the stall.
            PCwrite      = 1'b0;
            IFIDwrite    = 1'b0;
            IDEXbubble   = 1'b1;
            stall_inc    = 1'b1;
            stall_left_d = need_n - 2'd1;
            state_d      = (need_n > 2'd1) ? STALL : RUN;
          end else if (taken) begin
            IFIDflush    = 1'b1;
            flush_inc    = 1'b1;
          end
        end
        STALL: begin
          // Remaining stall cycles are forced without re-checking hazards.
          PCwrite      = 1'b0;
          IFIDwrite    = 1'b0;
          IDEXbubble   = 1'b1;
          stall_inc    = 1'b1;
          stall_left_d = stall_left_q - 2'd1;
          if (stall_left_q <= 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // FSM state and remaining-stall register.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    stall_left_q <= stall_left_d;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and redirect controller for the 5-stage MIPS pipeline. Generates the fetch-side write enables (`PCwrite`, IF/ID write, IF/ID flush) and the ID/EX bubble, and freezes the pipe while instruction memory is not ready. It handles three cases: load-use stalls, stalls for branches resolved in ID, and taken branch/jump flushes. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `CNT_W`, 16, width of performance counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_ready`  in  1  instruction memory ready; 0 freezes the pipe.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads `rt`; branches drive 1.
- `id_beq`, `id_bne`, `id_jmp`  in  1 each  ID instruction type.
- `id_eq`  in  1  ID register comparator result.
- `ex_regwrite`, `ex_memread`  in  1 each  EX instruction writes a register / is a load.
- `ex_rd`  in  5  EX destination register, already muxed.
- `mem_memread`  in  1  MEM instruction is a load.
- `mem_rd`  in  5  MEM destination register.
- `PCwrite`  out  1  PC update enable.
- `IFIDwrite`  out  1  IF/ID register enable.
- `IFIDflush`  out  1  zero the IF/ID register (NOP).
- `IDEXbubble`  out  1  insert a NOP into ID/EX.
- `pipe_hold`  out  1  hold all stage registers.
- `stall_cnt`  out  CNT_W  hazard stall cycles, saturating.
- `flush_cnt`  out  CNT_W  taken redirects, saturating.

## Operation
Definitions:
- `match(r)`: `r != 0` and (`r == id_rs`, or `id_uses_rt` and `r == id_rt`).
- `br`: `id_beq | id_bne`.
- `taken`: `id_jmp | (id_beq & id_eq) | (id_bne & ~id_eq)`.

Stall demand N, evaluated in RUN; highest value wins:
- `br & ex_memread & match(ex_rd)` -> N = 2.
- `~br & ex_memread & match(ex_rd)` -> N = 1.
- `br & ex_regwrite & ~ex_memread & match(ex_rd)` -> N = 1.
- `br & mem_memread & match(mem_rd)` -> N = 1.
- Otherwise N = 0.

FSM states: RUN and STALL, plus a 2-bit `stall_left` counter.
- RUN, N > 0: stall outputs this cycle (`PCwrite`=0, `IFIDwrite`=0, `IDEXbubble`=1, `IFIDflush`=0). Set `stall_left` <= N-1. Next state is STALL if N-1 > 0, else RUN.
- RUN, N = 0, taken: `PCwrite`=1, `IFIDwrite`=1, `IFIDflush`=1, `IDEXbubble`=0.
- RUN, N = 0, not taken: `PCwrite`=1, `IFIDwrite`=1, others 0.
- STALL: stall outputs forced with no hazard re-evaluation. Decrement `stall_left`; when it reaches 0, return to RUN.
- A stall always beats a redirect; the branch is resolved after the stall.
- `imem_ready`=0 in any state:
  - `pipe_hold`=1; `PCwrite`, `IFIDwrite`, `IFIDflush`, `IDEXbubble` all 0.
  - FSM state, `stall_left` and both counters hold.
  - The hazard condition is not evaluated.
- `stall_cnt` increments on each non-frozen stall-output cycle. `flush_cnt` increments on each non-frozen RUN taken cycle. Both saturate at all-ones.

## Timing
- Outputs are combinational from state plus inputs: the hazard response appears in the same cycle the hazard condition is present.
- State and counters update on the rising edge of `clk`.
- Reset (`rst`=1, synchronous):
  - Next state RUN, `stall_left`=0, `stall_cnt`=0, `flush_cnt`=0.
  - While `rst` is high, outputs are forced: `PCwrite`=0, `IFIDwrite`=0, `IFIDflush`=1, `IDEXbubble`=1, `pipe_hold`=0.
  - Reset mid-STALL aborts the stall; the first cycle after reset is RUN.
- Latency: load-use costs 1 bubble. Branch after ALU producer costs 1. Branch after load costs 2 (both cycles after detection). Taken redirect costs 1 flushed slot.
- `imem_ready` low during STALL extends the stall by exactly the number of low cycles; `stall_left` resumes unchanged.
- `ex_rd` or `mem_rd` = 0 never stalls.

## Test plan
- Load `rt`=5 in EX (`ex_memread`=1, `ex_rd`=5), ID `add` with `id_rs`=5 -> one cycle of `PCwrite`=0, `IDEXbubble`=1; then RUN; `stall_cnt`=1.
- `beq` in ID with `id_rt`=7 and load `ex_rd`=7 -> two consecutive stall cycles (RUN then STALL), then RUN; `stall_cnt`=2.
- `bne` with `id_eq`=0 and no hazard -> `PCwrite`=1, `IFIDflush`=1 for one cycle; `flush_cnt`=1. Same with `id_eq`=1 -> no flush.
- Branch-after-load stall with `imem_ready`=0 for 3 cycles inserted after detection -> `pipe_hold`=1 for 3 cycles, then 1 remaining stall cycle; `stall_cnt`=2.
- Assert `rst` during STALL -> next cycle RUN with all counters 0. During the reset cycle `IFIDflush`=1 and `IDEXbubble`=1.
- Preload `flush_cnt` near all-ones by forcing 65536 taken jumps -> `flush_cnt` holds at 16'hFFFF.
